// File: rtl/and_loader_pkg.sv
// Shared constants for the and_operand_loader slice: FSM state encodings,
// byte-index width and the default inter-byte timeout.
package and_loader_pkg;

  // FSM state encodings
  localparam logic [1:0] LOAD_A  = 2'd0;
  localparam logic [1:0] LOAD_B  = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;

  // WIDTH tops out at 32 bits, so an operand never needs more than 4 bytes
  localparam int MAX_NBYTES = 4;
  localparam int IDX_W      = $clog2(MAX_NBYTES);

  // Inter-byte timeout, in clk cycles, when the timeout build option is used
  localparam int DEFAULT_TIMEOUT_CYCLES = 50000000;

endpackage

// File: rtl/and_operand_loader_byte_assembler.sv
// byte_assembler: WIDTH-bit register that drops an incoming byte into the
// byte lane selected by idx (little-endian). Bits of the top lane beyond
// WIDTH are discarded. nxt is the value the register takes if load is high
// this cycle, so a consumer can capture the finished operand on the same
// edge as its final byte.
module byte_assembler
  import and_loader_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int NBYTES = (WIDTH + 7) / 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       data,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] nxt
);

  localparam int PAD_W = NBYTES * 8;

  logic [PAD_W-1:0] wide;
  logic             unused_wide;

  // Merge the incoming byte into its lane over a byte-padded copy of value
  always_comb begin
    wide = '0;
    wide[WIDTH-1:0] = value;
    for (int k = 0; k < NBYTES; k++) begin
      if (int'(idx) == k) begin
        wide[k*8 +: 8] = data;
      end
    end
  end

  assign nxt         = wide[WIDTH-1:0];
  assign unused_wide = ^wide;

  // Operand register: cleared on request, otherwise loads the merged value
  always_ff @(posedge clk) begin
    if (clr) begin
      value <= '0;
    end else if (load) begin
      value <= nxt;
    end
  end

endmodule

// File: rtl/and_operand_loader.sv
// and_operand_loader: assembles operands a and b from a byte stream and
// presents the pair to basic_and with a valid/ready handshake. a/b only
// change when a complete pair is ready; they never show partial shifts.
// Build option AND_OPERAND_LOADER_TIMEOUT_EN adds an inter-byte timeout
// that abandons a partial frame and pulses frame_err; without it frame_err
// is tied low and a partial frame waits indefinitely.
module and_operand_loader
  import and_loader_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int NBYTES         = (WIDTH + 7) / 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             frame_err
);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             last_byte;
  logic             load_a;
  logic             load_b;
  logic             abort;
  logic             asm_clr;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] unused_a_nxt;
  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] b_nxt;

  // No bypass: bytes are refused for the whole PRESENT cycle(s)
  assign in_ready  = (state != PRESENT);
  assign op_valid  = (state == PRESENT);
  assign accept    = in_valid && in_ready;
  assign last_byte = (idx == IDX_W'(NBYTES - 1));
  assign load_a    = accept && (state == LOAD_A);
  assign load_b    = accept && (state == LOAD_B);
  assign asm_clr   = !rst_n || abort;

  byte_assembler #(.WIDTH(WIDTH), .NBYTES(NBYTES)) u_asm_a (
    .clk   (clk),
    .clr   (asm_clr),
    .load  (load_a),
    .idx   (idx),
    .data  (in_data),
    .value (a_shift),
    .nxt   (unused_a_nxt)
  );

  byte_assembler #(.WIDTH(WIDTH), .NBYTES(NBYTES)) u_asm_b (
    .clk   (clk),
    .clr   (asm_clr),
    .load  (load_b),
    .idx   (idx),
    .data  (in_data),
    .value (b_shift),
    .nxt   (b_nxt)
  );

`ifdef AND_OPERAND_LOADER_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        tmo_running;

  // A frame is in flight once the first A byte has landed
  assign tmo_running = ((state == LOAD_A) && (idx != '0)) || (state == LOAD_B);
  // An accepted byte on the expiry cycle wins over the abort
  assign abort = tmo_running && !accept && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Inter-byte idle counter, restarted by every accepted byte
  always_ff @(posedge clk) begin
    if (!rst_n || !tmo_running || accept) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  // frame_err is a one-cycle pulse following the abort edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= abort;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign abort     = 1'b0;
  assign frame_err = 1'b0;
`endif

  // Frame sequencing: fill A, fill B, then hold the pair until accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD_A;
      idx   <= '0;
    end else if (abort) begin
      state <= LOAD_A;
      idx   <= '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (accept) begin
            if (last_byte) begin
              idx   <= '0;
              state <= LOAD_B;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            if (last_byte) begin
              idx   <= '0;
              state <= PRESENT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        PRESENT: begin
          if (op_ready) begin
            state <= LOAD_A;
          end
        end
        default: begin
          state <= LOAD_A;
          idx   <= '0;
        end
      endcase
    end
  end

  // Output operands publish only when the final B byte lands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
    end else if (load_b && last_byte) begin
      a <= a_shift;
      b <= b_nxt;
    end
  end

endmodule

// File: tb/tb_and_operand_loader.sv
// Self-checking bench for and_operand_loader (WIDTH=12, two bytes per
// operand, TIMEOUT_CYCLES=16). A byte-queue model tracks frames and pairs;
// a negedge process compares every output against it each cycle, and
// directed sequences pin literal values.
module tb_and_operand_loader;

  localparam int W  = 12;
  localparam int NB = (W + 7) / 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op_valid;
  logic         op_ready;
  logic         frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  and_operand_loader #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0]   mq[$];
  bit           m_pres = 1'b0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  bit           m_err = 1'b0;
  int           m_idle = 0;

  function automatic logic [W-1:0] assemble(input int off);
    logic [31:0] v;
    v = 32'd0;
    for (int k = 0; k < NB; k++) v = v | (32'(mq[off + k]) << (8 * k));
    return v[W-1:0];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_pres = 1'b0; m_a = '0; m_b = '0; m_err = 1'b0; m_idle = 0;
    end else begin
      m_err = 1'b0;
      if (m_pres) begin
        if (op_ready) m_pres = 1'b0;
      end else if (in_valid) begin
        mq.push_back(in_data);
        m_idle = 0;
        if (mq.size() == 2 * NB) begin
          m_a = assemble(0);
          m_b = assemble(NB);
          m_pres = 1'b1;
          mq.delete();
        end
      end else if (mq.size() > 0) begin
`ifdef AND_OPERAND_LOADER_TIMEOUT_EN
        m_idle++;
        if (m_idle == TO) begin
          mq.delete();
          m_idle = 0;
          m_err = 1'b1;
        end
`endif
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_in_ready", 32'(in_ready), 32'(!m_pres));
      check("model_op_valid", 32'(op_valid), 32'(m_pres));
      check("model_a", 32'(a), 32'(m_a));
      check("model_b", 32'(b), 32'(m_b));
      check("model_frame_err", 32'(frame_err), 32'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   seq[8];
    logic [W-1:0] got_a[$];
    logic [W-1:0] got_b[$];
    int           pulses;
    int           si;
    int           gap;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; op_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_a", 32'(a), 32'd0);
    check("rst_b", 32'(b), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);

    // Multi-byte operands with upper nibble of the top byte discarded, held pair
    send_byte(8'h34); send_byte(8'hF2); send_byte(8'hCD); send_byte(8'h0B);
    check("pair1_op_valid", 32'(op_valid), 32'd1);
    check("pair1_a", 32'(a), 32'h234);
    check("pair1_b", 32'(b), 32'hBCD);
    check("pair1_and", 32'(a & b), 32'h204);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'hEE;
      @(negedge clk);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_a", 32'(a), 32'h234);
      check("hold_b", 32'(b), 32'hBCD);
    end
    in_valid = 1'b0;
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    check("hs_op_valid", 32'(op_valid), 32'd0);
    check("hs_in_ready", 32'(in_ready), 32'd1);
    check("hs_a_kept", 32'(a), 32'h234);

    // Reset mid-frame discards the partial byte
    send_byte(8'h11);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_a", 32'(a), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("midrst_pair_a", 32'(a), 32'h201);
    check("midrst_pair_b", 32'(b), 32'h403);
    op_ready = 1'b1;
    @(negedge clk);

    // Back-to-back pairs, op_ready held high, in_valid gated by in_ready
    seq = '{8'h0E, 8'h00, 8'h07, 8'h00, 8'h06, 8'h00, 8'h0C, 8'h00};
    si = 0;
    for (int c = 0; c < 40; c++) begin
      if (op_valid) begin
        got_a.push_back(a);
        got_b.push_back(b);
      end
      if (si < 8 && in_ready) begin
        in_valid = 1'b1; in_data = seq[si]; si++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_bytes_used", 32'(si), 32'd8);
    check("b2b_pulses", 32'(got_a.size()), 32'd2);
    if (got_a.size() == 2) begin
      check("b2b_a0", 32'(got_a[0]), 32'h00E);
      check("b2b_b0", 32'(got_b[0]), 32'h007);
      check("b2b_a1", 32'(got_a[1]), 32'h006);
      check("b2b_b1", 32'(got_b[1]), 32'h00C);
    end
    op_ready = 1'b0;

    // Partial frame left idle
    send_byte(8'h55);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (frame_err) pulses++;
      @(negedge clk);
    end
`ifdef AND_OPERAND_LOADER_TIMEOUT_EN
    check("tmo_pulses", 32'(pulses), 32'd1);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h09); send_byte(8'h00);
    check("tmo_pair_valid", 32'(op_valid), 32'd1);
    check("tmo_pair_a", 32'(a), 32'h003);
    check("tmo_pair_b", 32'(b), 32'h009);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
`else
    check("notmo_pulses", 32'(pulses), 32'd0);
    check("notmo_still_loading", 32'(in_ready), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Randomised traffic with idle bursts and occasional resets
    gap = 0;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if (gap == 0 && $urandom_range(0, 79) == 0) gap = $urandom_range(8, 24);
      if (gap > 0) begin
        in_valid = 1'b0;
        gap--;
      end else begin
        in_valid = ($urandom_range(0, 2) != 0);
      end
      in_data  = 8'($urandom);
      op_ready = ($urandom_range(0, 1) != 0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/and_operand_loader.md
Name: and_operand_loader

Overview:
- Upstream feeder for basic_and. Assembles operands a and b from a byte stream, for example the serial receive bytes on the Mojo board.
- Presents the completed a/b pair to the AND stage with a valid/ready handshake.
- Holds each operand pair stable until the consumer accepts it.
- Lets the board exercise basic_and with arbitrary WIDTH operands over a byte-wide link.

Parameters:
- WIDTH, 4: operand width in bits (1..32); matches basic_and WIDTH.
- NBYTES, (WIDTH+7)/8: bytes per operand; derived, not overridden.
- TIMEOUT_CYCLES, 50000000: inter-byte timeout in clk cycles; used only when the timeout feature is compiled in.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- in_data  input  8  incoming byte
- in_valid  input  1  in_data valid this cycle
- in_ready  output  1  loader can accept a byte
- a  output  WIDTH  operand A to basic_and
- b  output  WIDTH  operand B to basic_and
- op_valid  output  1  a/b pair complete and stable
- op_ready  input  1  consumer accepts the pair
- frame_err  output  1  one-cycle pulse on partial-frame abort

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous, active-low on rst_n, sampled on the rising edge of clk.
  - Reset values: a=0, b=0, op_valid=0, in_ready=1, frame_err=0, state=LOAD_A, byte index=0.
  - Reset asserted mid-frame or mid-present discards everything; no partial data survives.
- Byte acceptance:
  - A byte is accepted when in_valid && in_ready at a rising edge.
  - Bytes are little-endian: the first byte fills bits [7:0], the next fills [15:8], and so on.
  - Bits of the last byte above WIDTH are discarded. For example, with WIDTH=4, only in_data[3:0] of each byte is used.
- State machine:
  - LOAD_A: in_ready=1. Each accepted byte goes into the A shift register and the index increments. On byte NBYTES-1, clear the index and go to LOAD_B.
  - LOAD_B: in_ready=1. Same as LOAD_A but fills B. On the final byte, go to PRESENT. a/b outputs update from the shift registers on that same edge.
  - PRESENT: op_valid=1, in_ready=0. a and b are held constant. On op_ready at an edge, go to LOAD_A next cycle with op_valid=0.
- Latency and throughput:
  - op_valid rises in the cycle after the last B byte is accepted.
  - There is no same-cycle bypass from PRESENT to byte acceptance: in_ready rises the cycle after the handshake.
  - Throughput is 2*NBYTES+1 cycles per pair minimum.
- Output holding: a/b keep the last presented values after the handshake until the next pair completes. They do not track partial shifts.
- Handshake rule: op_valid never drops without op_ready. A consumer holding op_ready=1 continuously accepts each pair the cycle it appears.

Optional Feature:
- Macro: AND_OPERAND_LOADER_TIMEOUT_EN.
- Defined:
  - A counter runs while in LOAD_A with index>0, or in LOAD_B. It clears on every accepted byte.
  - On reaching TIMEOUT_CYCLES-1, the state returns to LOAD_A, the index clears, and frame_err pulses high for one cycle.
  - a/b outputs are unchanged by the abort.
  - A byte accepted in the same cycle as the timeout wins: the counter clears and no abort occurs.
- Undefined: no counter is built, frame_err is tied to 0, and a partial frame waits indefinitely.

Decomposition:
- Shared package/header and_loader_pkg:
  - State encodings LOAD_A=2'd0, LOAD_B=2'd1, PRESENT=2'd2.
  - Byte index width constant, clog2 of the maximum NBYTES.
  - Default TIMEOUT_CYCLES constant.
- One natural sub-module, byte_assembler:
  - Parameterised WIDTH register that shifts a byte into position by index, with a clear input.
  - Instantiated twice, once for A and once for B.
- FSM, handshake and timeout logic stay in the top module.

Test Plan:
- WIDTH=4, bytes 0x0F then 0x05 with op_ready=1 -> op_valid one cycle after 2nd byte, a=4'hF, b=4'h5, basic_and out=4'h5.
- WIDTH=4, bytes 0xA6 then 0x3C with op_ready=0 for 10 cycles -> a=4'h6, b=4'hC held, in_ready=0 throughout; op_ready=1 -> op_valid=0 and in_ready=1 next cycle.
- WIDTH=12, bytes 0x34,0xF2,0xCD,0x0B -> a=12'h234, b=12'hBCD; upper nibbles discarded.
- Reset: rst_n low one cycle after the first A byte -> all outputs at reset values; the next two bytes 0x01,0x02 yield a=1, b=2.
- Back-to-back pairs (0x0E,0x07) then (0x06,0x0C) with op_ready=1 and in_valid gated by in_ready -> two op_valid pulses presenting 4'hE/4'h7 then 4'h6/4'hC; no byte lost.
- With AND_OPERAND_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: one A byte then idle 16 cycles -> frame_err pulses once, state returns to LOAD_A; the next bytes 0x03,0x09 give a=3, b=9.
